// File: rtl/bcd_scan_pkg.sv
// Shared types and constants for the time-multiplexed binary-to-BCD scan scheduler.
package bcd_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } state_t;

    localparam int unsigned BCD_ADJ        = 3;
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam logic [11:0] BCD_BLANK      = 12'hFFF;

endpackage

// File: rtl/bcd_scan_sched_dabble.sv
// Sequential shift-add-3 (double dabble) engine: one load, then W single-bit steps.
module bcd_dabble_core
    import bcd_scan_pkg::*;
#(
    parameter int W  = 10,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [W-1:0]  bin_in,
    output logic [DW-1:0] bcd_out,
    output logic          last_step
);

    localparam int ND = DW / 4;
    localparam int SW = $clog2(W + 1);

    logic [W-1:0]  sr;
    logic [DW-1:0] bcd;
    logic [DW-1:0] adj;
    logic [SW-1:0] step_cnt;

    function automatic logic [DW-1:0] digit_adjust(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        for (int d = 0; d < ND; d++) begin
            if (v[4*d +: 4] >= 4'(BCD_ADJ_THRESH)) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'(BCD_ADJ);
            end
        end
        return r;
    endfunction

    always_comb begin
        adj = digit_adjust(bcd);
    end

    // Datapath: carry-out of the top digit falls off; the caller flags that range separately.
    always_ff @(posedge clk) begin
        if (load) begin
            sr  <= bin_in;
            bcd <= '0;
        end else if (step) begin
            bcd <= {adj[DW-2:0], sr[W-1]};
            sr  <= {sr[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (load) begin
            step_cnt <= '0;
        end else if (step) begin
            step_cnt <= step_cnt + SW'(1);
        end
    end

    assign last_step = step && (step_cnt == SW'(W - 1));
    assign bcd_out   = bcd;

endmodule

// File: rtl/bcd_scan_sched.sv
// Shares one double-dabble core across L display channels, one channel per W+2 cycles.
// Optional macro BCD_SCAN_TICKQ_EN queues one tick that arrives while a frame is running.
module bcd_scan_sched
    import bcd_scan_pkg::*;
#(
    parameter int L  = 10,
    parameter int W  = 10,
    parameter int DW = 12
) (
    input  logic            clk,
    input  logic            RSTn,
    input  logic            tick,
    input  logic [L*W-1:0]  bin,
    output logic [L*DW-1:0] dec,
    output logic [L-1:0]    ovf,
    output logic            busy,
    output logic            frame_done
);

    localparam int          CW    = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned LIMIT = 10 ** (DW / 4);
    localparam logic [DW-1:0] BLANK = (DW == 12) ? DW'(BCD_BLANK) : {DW{1'b1}};

    state_t        state;
    logic [CW-1:0] ch;
    logic [L*W-1:0] snap;
    logic [W-1:0]  snap_ch [L];
    logic [W-1:0]  cur_val;
    logic          ovf_cur;
    logic [DW-1:0] bank [L];
    logic [DW-1:0] bcd;
    logic          last_step;
    logic          last_ch;
    logic          restart;
    logic          snap_en;

    function automatic logic over_limit(input logic [W-1:0] v);
        return 32'(v) >= 32'(LIMIT);
    endfunction

    function automatic logic [DW-1:0] store_code(input logic [DW-1:0] v, input logic blank);
        return blank ? BLANK : v;
    endfunction

    for (genvar g = 0; g < L; g++) begin : g_slot
        assign snap_ch[g]               = snap[W*(L-g)-1 -: W];
        assign dec[DW*(L-g)-1 -: DW]    = bank[g];
    end

    assign cur_val = snap_ch[ch];
    assign last_ch = (ch == CW'(L - 1));
    assign busy    = (state != IDLE);

`ifdef BCD_SCAN_TICKQ_EN
    logic pending;

    // A tick landing on the final STORE edge is consumed directly by the restart.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            pending <= 1'b0;
        end else if (state == STORE && last_ch) begin
            pending <= 1'b0;
        end else if (tick && state != IDLE) begin
            pending <= 1'b1;
        end
    end

    assign restart = pending | tick;
`else
    assign restart = 1'b0;
`endif

    assign snap_en = (state == IDLE && tick) || (state == STORE && last_ch && restart);

    always_ff @(posedge clk) begin
        if (snap_en) begin
            snap <= bin;
        end
        if (state == LOAD) begin
            ovf_cur <= over_limit(cur_val);
        end
    end

    bcd_dabble_core #(
        .W  (W),
        .DW (DW)
    ) u_core (
        .clk       (clk),
        .rst_n     (RSTn),
        .load      (state == LOAD),
        .step      (state == SHIFT),
        .bin_in    (cur_val),
        .bcd_out   (bcd),
        .last_step (last_step)
    );

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            ch         <= '0;
            frame_done <= 1'b0;
            ovf        <= '0;
            for (int i = 0; i < L; i++) begin
                bank[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        ch    <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (last_step) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    bank[ch] <= store_code(bcd, ovf_cur);
                    ovf[ch]  <= ovf_cur;
                    if (last_ch) begin
                        frame_done <= 1'b1;
                        ch         <= '0;
                        state      <= restart ? LOAD : IDLE;
                    end else begin
                        ch    <= ch + CW'(1);
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
